// File: rtl/rgb_hue_pwm_ctrl.sv
// rgb_hue_pwm_ctrl: HSV hue-wheel RGB PWM driver with global brightness and breathe envelope
module rgb_hue_pwm_ctrl #(
  parameter int PWM_WIDTH     = 8,
  parameter int STEP_INTERVAL = 33333
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [PWM_WIDTH-1:0] brightness,
  input  logic                 hue_load,
  input  logic [8:0]           hue_in,
  output logic [8:0]           hue_out,
  output logic                 period_start,
  output logic                 RGB_R,
  output logic                 RGB_G,
  output logic                 RGB_B
);
  localparam int W  = PWM_WIDTH;
  localparam int TW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [W-1:0]  MAX   = {W{1'b1}};
  localparam logic [TW-1:0] TLAST = TW'(STEP_INTERVAL - 1);
  localparam logic [1:0]    M_UP  = 2'b01;
  localparam logic [1:0]    M_DN  = 2'b10;
  localparam logic [1:0]    M_BR  = 2'b11;

  typedef enum logic {UP, DOWN} br_state_e;

  logic [TW-1:0]      tick_q, tick_d;
  logic               tick;
  logic [8:0]         hue_q, hue_d;
  br_state_e          br_q;
  logic [W-1:0]       level_q;
  logic [W-1:0]       pwm_q;
  logic               ps_q;
  logic [W:0]         lvl1, s1;
  logic [2*W-1:0]     bprod;
  logic [W-1:0]       scale;
  logic [2:0][W-1:0]  raw, dn_d, dn_q, da_q;

  function automatic logic [W-1:0] ramp(input logic [8:0] x);
    logic [W+6:0] p;
    p = (W+7)'(MAX) * (W+7)'(x);
    return W'(p / (W+7)'(60));
  endfunction

  // Tick divider next-state and hue stepping (load beats tick)
  always_comb begin
    tick   = en && (tick_q == TLAST);
    tick_d = !en ? tick_q : tick ? '0 : tick_q + TW'(1);
    hue_d  = hue_load ? ((hue_in > 9'd359) ? 9'd359 : hue_in)
           : !tick ? hue_q
           : (mode == M_UP) ? ((hue_q == 9'd359) ? 9'd0 : hue_q + 9'd1)
           : (mode == M_DN) ? ((hue_q == 9'd0) ? 9'd359 : hue_q - 9'd1)
           : hue_q;
  end

  // Divider and hue registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      hue_q  <= '0;
    end else begin
      tick_q <= tick_d;
      hue_q  <= hue_d;
    end
  end

  // Breathe envelope: triangle 0..MAX..0, forced dark outside breathe mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q    <= UP;
      level_q <= '0;
    end else if (mode != M_BR) begin
      br_q    <= UP;
      level_q <= '0;
    end else if (tick) begin
      if (br_q == UP) begin
        br_q    <= (level_q == MAX - W'(1)) ? DOWN : UP;
        level_q <= level_q + W'(1);
      end else begin
        br_q    <= (level_q == W'(1)) ? UP : DOWN;
        level_q <= level_q - W'(1);
      end
    end
  end

  // Effective scale, hue-to-colour ramps and scaled duty for each channel
  always_comb begin
    lvl1   = {1'b0, level_q} + (W+1)'(1);
    bprod  = (2*W)'(brightness) * (2*W)'(lvl1);
    scale  = (mode == M_BR) ? W'(bprod >> W) : brightness;
    s1     = {1'b0, scale} + (W+1)'(1);
    raw[0] = (hue_q < 9'd60 || hue_q >= 9'd300) ? MAX
           : (hue_q < 9'd120) ? ramp(9'd120 - hue_q)
           : (hue_q < 9'd240) ? '0
           : ramp(hue_q - 9'd240);
    raw[1] = (hue_q < 9'd60) ? ramp(hue_q)
           : (hue_q < 9'd180) ? MAX
           : (hue_q < 9'd240) ? ramp(9'd240 - hue_q)
           : '0;
    raw[2] = (hue_q < 9'd120) ? '0
           : (hue_q < 9'd180) ? ramp(hue_q - 9'd120)
           : (hue_q < 9'd300) ? MAX
           : ramp(9'd360 - hue_q);
    for (int c = 0; c < 3; c++) dn_d[c] = W'(((2*W)'(raw[c]) * (2*W)'(s1)) >> W);
  end

  // PWM counter; pending duties only take effect at the period wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
      ps_q  <= 1'b0;
      dn_q  <= '0;
      da_q  <= '0;
    end else begin
      pwm_q <= pwm_q + W'(1);
      ps_q  <= (pwm_q == MAX);
      dn_q  <= dn_d;
      if (pwm_q == MAX) da_q <= dn_q;
    end
  end

  assign hue_out      = hue_q;
  assign period_start = ps_q;
  assign RGB_R        = pwm_q < da_q[0];
  assign RGB_G        = pwm_q < da_q[1];
  assign RGB_B        = pwm_q < da_q[2];
endmodule

// File: tb/tb_rgb_hue_pwm_ctrl.sv
// tb_rgb_hue_pwm_ctrl: randomized self-checking bench against a hue-wheel reference model
module tb_rgb_hue_pwm_ctrl;
  localparam int PW   = 8;
  localparam int MAX  = 255;
  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       hue_load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] brightness = 8'd0;
  logic [8:0] hue_in = 9'd0;
  logic [8:0] hue_out, b_hue_out;
  logic       period_start, RGB_R, RGB_G, RGB_B;
  logic       b_ps, b_r, b_g, b_b;
  int         n_checks = 0;
  int         n_pass = 0;
  int         ecnt;

  always #5 clk = ~clk;

  rgb_hue_pwm_ctrl #(.PWM_WIDTH(PW), .STEP_INTERVAL(STEP)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .brightness(brightness),
    .hue_load(hue_load), .hue_in(hue_in), .hue_out(hue_out), .period_start(period_start),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  rgb_hue_pwm_ctrl #(.PWM_WIDTH(PW), .STEP_INTERVAL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .brightness(brightness),
    .hue_load(hue_load), .hue_in(hue_in), .hue_out(b_hue_out), .period_start(b_ps),
    .RGB_R(b_r), .RGB_G(b_g), .RGB_B(b_b)
  );

  // enabled clock edges since reset; the divider phase is ecnt % STEP
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt <= 0;
    else if (en) ecnt <= ecnt + 1;

  // colour wheel: each channel is the red curve rotated by 120 degrees
  function automatic int raw_ref(input int h, input int ch);
    int x, d;
    x = (h - 120 * ch + 360) % 360;
    d = (x > 180) ? 360 - x : x;
    if (d <= 60) return MAX;
    if (d >= 120) return 0;
    return MAX * (120 - d) / 60;
  endfunction

  function automatic int duty_ref(input int raw, input int s);
    return (raw * (s + 1)) >> PW;
  endfunction

  function automatic int tri_lvl(input int k);
    int m;
    m = k % (2 * MAX);
    return (m <= MAX) ? m : 2 * MAX - m;
  endfunction

  task automatic do_reset(input logic [1:0] m, input logic [7:0] br);
    rst_n = 1'b0; mode = m; brightness = br; en = 1'b1; hue_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step_to_tick;
    for (int i = 0; i < STEP && (ecnt % STEP) != STEP - 1; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic measure(output int rc, output int gc, output int bc);
    rc = -1; gc = -1; bc = -1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 600 && !period_start; i++) @(negedge clk);
    if (period_start) begin
      rc = 0; gc = 0; bc = 0;
      for (int k = 0; k < 256; k++) begin
        rc += int'(RGB_R); gc += int'(RGB_G); bc += int'(RGB_B);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (hue_out !== 9'd0) $display("FAIL reset_hue: got %0d expected 0", hue_out); else n_pass++;
    n_checks++;
    if (period_start !== 1'b0) $display("FAIL reset_ps: got %0b expected 0", period_start); else n_pass++;
    n_checks++;
    if ({RGB_R, RGB_G, RGB_B, b_r, b_g, b_b} !== 6'b0)
      $display("FAIL reset_rgb: got %b expected 000000", {RGB_R, RGB_G, RGB_B, b_r, b_g, b_b});
    else n_pass++;
  endtask

  task automatic test_cycle_up;
    int exp, kb, hb, cnt;
    logic [2:0] erg;
    do_reset(2'b01, 8'd255);
    for (int k = 1; k <= 1448; k++) begin
      @(negedge clk);
      exp = (k / STEP) % 360;
      n_checks++;
      if (hue_out !== 9'(exp)) $display("FAIL cycle_hue k=%0d: got %0d expected %0d", k, hue_out, exp);
      else n_pass++;
    end
    cnt = 1448 % 256;
    kb  = 1448 - cnt;
    hb  = ((kb - 2) / STEP) % 360;
    for (int c = 0; c < 3; c++) erg[2-c] = duty_ref(raw_ref(hb, c), 255) > cnt;
    n_checks++;
    if ({RGB_R, RGB_G, RGB_B} !== erg) $display("FAIL midperiod_rgb: got %b expected %b", {RGB_R, RGB_G, RGB_B}, erg);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({RGB_R, RGB_G, RGB_B} !== 3'b0) $display("FAIL async_reset_rgb: got %b expected 000", {RGB_R, RGB_G, RGB_B});
    else n_pass++;
    n_checks++;
    if (hue_out !== 9'd0) $display("FAIL async_reset_hue: got %0d expected 0", hue_out); else n_pass++;
  endtask

  task automatic test_cycle_down;
    do_reset(2'b10, 8'd255);
    hue_load = 1'b1; hue_in = 9'd0;
    @(negedge clk);
    hue_load = 1'b0;
    n_checks++;
    if (hue_out !== 9'd0) $display("FAIL down_load0: got %0d expected 0", hue_out); else n_pass++;
    step_to_tick;
    n_checks++;
    if (hue_out !== 9'd359) $display("FAIL down_wrap: got %0d expected 359", hue_out); else n_pass++;
    step_to_tick;
    n_checks++;
    if (hue_out !== 9'd358) $display("FAIL down_step: got %0d expected 358", hue_out); else n_pass++;
    hue_load = 1'b1; hue_in = 9'd400;
    @(negedge clk);
    hue_load = 1'b0;
    n_checks++;
    if (hue_out !== 9'd359) $display("FAIL load_clamp: got %0d expected 359", hue_out); else n_pass++;
    for (int i = 0; i < STEP && (ecnt % STEP) != STEP - 1; i++) @(negedge clk);
    hue_load = 1'b1; hue_in = 9'd77;
    @(negedge clk);
    hue_load = 1'b0;
    n_checks++;
    if (hue_out !== 9'd77) $display("FAIL load_vs_tick: got %0d expected 77", hue_out); else n_pass++;
    step_to_tick;
    n_checks++;
    if (hue_out !== 9'd76) $display("FAIL down_after_load: got %0d expected 76", hue_out); else n_pass++;
  endtask

  task automatic test_colour;
    int hv[11], bv[11];
    int rc, gc, bc, h, er, eg, eb;
    hv[0] = 90;  bv[0] = 255;
    hv[1] = 300; bv[1] = 255;
    hv[2] = 180; bv[2] = 255;
    hv[3] = 0;   bv[3] = 128;
    hv[4] = 0;   bv[4] = 0;
    for (int i = 5; i < 11; i++) begin
      hv[i] = int'($urandom_range(0, 511));
      bv[i] = int'($urandom_range(0, 255));
    end
    mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      hue_in = 9'(hv[i]); brightness = 8'(bv[i]); hue_load = 1'b1;
      @(negedge clk);
      hue_load = 1'b0;
      measure(rc, gc, bc);
      h  = (hv[i] > 359) ? 359 : hv[i];
      er = duty_ref(raw_ref(h, 0), bv[i]);
      eg = duty_ref(raw_ref(h, 1), bv[i]);
      eb = duty_ref(raw_ref(h, 2), bv[i]);
      n_checks++;
      if (rc !== er) $display("FAIL colour_r hue=%0d br=%0d: got %0d expected %0d", hv[i], bv[i], rc, er); else n_pass++;
      n_checks++;
      if (gc !== eg) $display("FAIL colour_g hue=%0d br=%0d: got %0d expected %0d", hv[i], bv[i], gc, eg); else n_pass++;
      n_checks++;
      if (bc !== eb) $display("FAIL colour_b hue=%0d br=%0d: got %0d expected %0d", hv[i], bv[i], bc, eb); else n_pass++;
    end
  endtask

  task automatic test_glitch_and_freeze;
    int rc, gc, bc, n_ps;
    int od[3], nd[3], cnt[3];
    logic [2:0] e0;
    for (int c = 0; c < 3; c++) begin
      od[c] = duty_ref(raw_ref(0, c), 255);
      nd[c] = duty_ref(raw_ref(120, c), 255);
    end
    mode = 2'b00; brightness = 8'd255; hue_in = 9'd0; hue_load = 1'b1;
    @(negedge clk);
    hue_load = 1'b0;
    measure(rc, gc, bc);
    n_checks++;
    if (rc !== od[0]) $display("FAIL glitch_settle_r: got %0d expected %0d", rc, od[0]); else n_pass++;
    for (int i = 0; i < 300 && !period_start; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    hue_in = 9'd120; hue_load = 1'b1;
    cnt = '{0, 0, 0};
    for (int i = 100; i < 256; i++) begin
      cnt[0] += int'(RGB_R); cnt[1] += int'(RGB_G); cnt[2] += int'(RGB_B);
      @(negedge clk);
      hue_load = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (cnt[c] !== ((od[c] > 100) ? od[c] - 100 : 0))
        $display("FAIL glitch_old_tail ch=%0d: got %0d expected %0d", c, cnt[c], (od[c] > 100) ? od[c] - 100 : 0);
      else n_pass++;
    end
    n_checks++;
    if (period_start !== 1'b1) $display("FAIL glitch_boundary_ps: got %0b expected 1", period_start); else n_pass++;
    e0 = {nd[0] > 0, nd[1] > 0, nd[2] > 0};
    n_checks++;
    if ({RGB_R, RGB_G, RGB_B} !== e0) $display("FAIL glitch_boundary_rgb: got %b expected %b", {RGB_R, RGB_G, RGB_B}, e0);
    else n_pass++;
    cnt = '{0, 0, 0};
    for (int i = 0; i < 256; i++) begin
      cnt[0] += int'(RGB_R); cnt[1] += int'(RGB_G); cnt[2] += int'(RGB_B);
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (cnt[c] !== nd[c]) $display("FAIL glitch_new_period ch=%0d: got %0d expected %0d", c, cnt[c], nd[c]); else n_pass++;
    end
    mode = 2'b01; en = 1'b0; n_ps = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      n_ps += int'(period_start);
    end
    n_checks++;
    if (hue_out !== 9'd120) $display("FAIL freeze_hue: got %0d expected 120", hue_out); else n_pass++;
    n_checks++;
    if (n_ps !== 2) $display("FAIL freeze_pwm_runs: got %0d period starts expected 2", n_ps); else n_pass++;
    en = 1'b1;
    repeat (2 * STEP) @(negedge clk);
    n_checks++;
    if (hue_out !== 9'd122) $display("FAIL unfreeze_hue: got %0d expected 122", hue_out); else n_pass++;
  endtask

  task automatic test_breathe;
    int j, e, rc, gc, exp, np, s;
    mode = 2'b00; en = 1'b1; brightness = 8'd255; hue_in = 9'd0; hue_load = 1'b1;
    @(negedge clk);
    hue_load = 1'b0; mode = 2'b11; np = 0;
    @(negedge clk);
    j = 1;
    while (j < 1400) begin
      if (b_ps) begin
        e = j; rc = 0; gc = 0;
        for (int i = 0; i < 256; i++) begin
          rc += int'(b_r); gc += int'(b_g);
          @(negedge clk);
          j++;
        end
        s   = (e < 2) ? 255 : (255 * (tri_lvl(e - 2) + 1)) >> PW;
        exp = duty_ref(MAX, s);
        np++;
        n_checks++;
        if (rc !== exp) $display("FAIL breathe_r edge=%0d: got %0d expected %0d", e, rc, exp); else n_pass++;
        n_checks++;
        if (gc !== 0) $display("FAIL breathe_g edge=%0d: got %0d expected 0", e, gc); else n_pass++;
      end else begin
        @(negedge clk);
        j++;
      end
    end
    n_checks++;
    if (np < 5) $display("FAIL breathe_periods: got %0d expected at least 5", np); else n_pass++;
    n_checks++;
    if (b_hue_out !== 9'd0) $display("FAIL breathe_hue_held: got %0d expected 0", b_hue_out); else n_pass++;
    mode = 2'b01; en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 600 && !b_ps; i++) @(negedge clk);
    rc = 0;
    for (int i = 0; i < 256; i++) begin
      rc += int'(b_r);
      @(negedge clk);
    end
    exp = duty_ref(MAX, 255);
    n_checks++;
    if (rc !== exp) $display("FAIL breathe_exit_r: got %0d expected %0d", rc, exp); else n_pass++;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_cycle_up;
    test_cycle_down;
    test_colour;
    test_glitch_and_freeze;
    test_breathe;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
